// File: rtl/multicycle_controller.sv
// multicycle_controller: sequencing FSM for the multi-cycle RV32I core.
// Steps the shared datapath through fetch/decode/execute/memory/writeback,
// stalls on the memory ready handshake, flags unsupported opcodes and
// counts retired instructions.
module multicycle_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       Opcode,
  input  logic [2:0]       funct3,
  input  logic             Zero,
  input  logic             Negflag,
  input  logic             Unsigned_less_than,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       ResultSrc,
  output logic [2:0]       ImmSrc,
  output logic [2:0]       Loadtype,
  output logic [1:0]       Storetype,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_JALR     = 4'd11;
  localparam logic [3:0] S_LINK     = 4'd12;
  localparam logic [3:0] S_LUI      = 4'd13;
  localparam logic [3:0] S_TRAP     = 4'd14;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic       branch_taken;
  logic       mem_req_c;
  logic       mem_write_c;
  logic       ir_write_c;
  logic       pc_write_c;
  logic       reg_write_c;

  // Branch condition from the ALU flags of the current cycle.
  always_comb begin
    branch_taken = 1'b0;
    case (funct3)
      3'b000:  branch_taken = Zero;
      3'b001:  branch_taken = ~Zero;
      3'b100:  branch_taken = Negflag;
      3'b101:  branch_taken = ~Negflag;
      3'b110:  branch_taken = Unsigned_less_than;
      3'b111:  branch_taken = ~Unsigned_less_than;
      default: branch_taken = 1'b0;
    endcase
  end

  // Next-state selection; request states hold until mem_ready.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (Opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_ALUWB;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR:   state_d = (Opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_JALR:     state_d = S_LINK;
      S_LINK:     state_d = S_FETCH;
      S_LUI:      state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_FETCH;
    endcase
  end

  // State register, retired counter and sticky illegal flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      retired <= '0;
      illegal <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q != S_FETCH && state_d == S_FETCH)
        retired <= retired + CNT_W'(1);
      if (state_q == S_TRAP)
        illegal <= 1'b1;
    end
  end

  // Per-state datapath controls; anything not set here stays 0.
  always_comb begin
    mem_req_c   = 1'b0;
    AdrSrc      = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    pc_write_c  = 1'b0;
    reg_write_c = 1'b0;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    ResultSrc   = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_req_c  = 1'b1;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        ir_write_c = mem_ready;
        pc_write_c = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: begin
        mem_req_c = 1'b1;
        AdrSrc    = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc   = 2'b01;
        reg_write_c = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req_c   = 1'b1;
        AdrSrc      = 1'b1;
        mem_write_c = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b11;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      S_ALUWB: reg_write_c = 1'b1;
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUOp      = 2'b01;
        pc_write_c = branch_taken;
      end
      S_JAL: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        pc_write_c = 1'b1;
      end
      S_JALR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ResultSrc  = 2'b10;
        pc_write_c = 1'b1;
      end
      S_LINK: begin
        ALUSrcA     = 2'b01;
        ALUSrcB     = 2'b10;
        ResultSrc   = 2'b10;
        reg_write_c = 1'b1;
      end
      S_LUI: begin
        ResultSrc   = 2'b11;
        reg_write_c = 1'b1;
      end
      default: ;
    endcase
  end

  // Strobes are suppressed while reset is high so an abandoned access
  // cannot leak a write.
  assign mem_req  = mem_req_c   & ~reset;
  assign MemWrite = mem_write_c & ~reset;
  assign IRWrite  = ir_write_c  & ~reset;
  assign PCWrite  = pc_write_c  & ~reset;
  assign RegWrite = reg_write_c & ~reset;

  // Immediate format selected from the opcode.
  always_comb begin
    ImmSrc = 3'b000;
    case (Opcode)
      OP_STORE:         ImmSrc = 3'b001;
      OP_BRANCH:        ImmSrc = 3'b010;
      OP_JAL:           ImmSrc = 3'b011;
      OP_LUI, OP_AUIPC: ImmSrc = 3'b100;
      default:          ImmSrc = 3'b000;
    endcase
  end

  // Load/store width encodings for the memory data path.
  always_comb begin
    Loadtype  = 3'b000;
    Storetype = 2'b10;
    if (Opcode == OP_LOAD) begin
      case (funct3)
        3'b000:  Loadtype = 3'b010;
        3'b001:  Loadtype = 3'b001;
        3'b010:  Loadtype = 3'b000;
        3'b100:  Loadtype = 3'b100;
        3'b101:  Loadtype = 3'b011;
        default: Loadtype = 3'b000;
      endcase
    end
    if (Opcode == OP_STORE) begin
      case (funct3)
        3'b000:  Storetype = 2'b00;
        3'b001:  Storetype = 2'b01;
        default: Storetype = 2'b10;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Testbench for multicycle_controller: directed test-plan instructions
// followed by randomized instruction streams with random memory stalls and
// ALU flags, checked against an instruction-level reference model.
module tb_multicycle_controller;

  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [6:0]       Opcode = 7'b0010011;
  logic [2:0]       funct3 = 3'b000;
  logic             Zero = 1'b0;
  logic             Negflag = 1'b0;
  logic             Unsigned_less_than = 1'b0;
  logic             mem_ready = 1'b1;
  logic             mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite;
  logic [1:0]       ALUSrcA, ALUSrcB, ALUOp, ResultSrc;
  logic [2:0]       ImmSrc, Loadtype;
  logic [1:0]       Storetype;
  logic             illegal;
  logic [CNT_W-1:0] retired;

  multicycle_controller #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .funct3(funct3),
    .Zero(Zero), .Negflag(Negflag), .Unsigned_less_than(Unsigned_less_than),
    .mem_ready(mem_ready), .mem_req(mem_req), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc),
    .Loadtype(Loadtype), .Storetype(Storetype), .illegal(illegal),
    .retired(retired)
  );

  always #5 clk = ~clk;

  // {mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite, A, B, Op, Res}
  logic [13:0] ctl_vec;
  assign ctl_vec = {mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite,
                    ALUSrcA, ALUSrcB, ALUOp, ResultSrc};

  typedef struct {
    logic [13:0] vec;
    bit          req;
    bit          fetch;
    bit          br;
  } step_t;

  step_t steps[$];
  int    ncmp = 0;
  int    nfail = 0;
  int    done = 0;

  logic [6:0] ops [9] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                          7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                          7'b0010111};

  function automatic logic [13:0] mk(bit mr, bit ad, bit mw, bit irw, bit pcw,
                                     bit rw, logic [1:0] a, logic [1:0] b,
                                     logic [1:0] op, logic [1:0] rs);
    return {mr, ad, mw, irw, pcw, rw, a, b, op, rs};
  endfunction

  function automatic step_t st(logic [13:0] v, bit req, bit fetch, bit br);
    step_t s;
    s.vec = v; s.req = req; s.fetch = fetch; s.br = br;
    return s;
  endfunction

  function automatic bit taken(logic [2:0] f3, bit z, bit n, bit u);
    bit flag;
    flag = (f3[2:1] == 2'b00) ? z : (f3[2:1] == 2'b10) ? n : u;
    if (f3[2:1] == 2'b01) return 1'b0;
    return f3[0] ? !flag : flag;
  endfunction

  function automatic logic [2:0] imm_of(logic [6:0] op);
    case (op)
      7'b0100011:             return 3'd1;
      7'b1100011:             return 3'd2;
      7'b1101111:             return 3'd3;
      7'b0110111, 7'b0010111: return 3'd4;
      default:                return 3'd0;
    endcase
  endfunction

  function automatic logic [2:0] lt_of(logic [6:0] op, logic [2:0] f3);
    logic [2:0] tab [8] = '{3'd2, 3'd1, 3'd0, 3'd0, 3'd4, 3'd3, 3'd0, 3'd0};
    return (op == 7'b0000011) ? tab[f3] : 3'd0;
  endfunction

  function automatic logic [1:0] stt_of(logic [6:0] op, logic [2:0] f3);
    if (op != 7'b0100011) return 2'd2;
    return (f3 == 3'd0) ? 2'd0 : (f3 == 3'd1) ? 2'd1 : 2'd2;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Micro-step list of one instruction, built from its class.
  task automatic build(input logic [6:0] op);
    step_t aluwb, fetch, decode, memadr;
    aluwb  = st(mk(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00), 0, 0, 0);
    fetch  = st(mk(1,0,0,0,0,0,2'b00,2'b10,2'b00,2'b10), 1, 1, 0);
    decode = st(mk(0,0,0,0,0,0,2'b01,2'b01,2'b00,2'b00), 0, 0, 0);
    memadr = st(mk(0,0,0,0,0,0,2'b10,2'b01,2'b00,2'b00), 0, 0, 0);
    steps.delete();
    steps.push_back(fetch);
    steps.push_back(decode);
    case (op)
      7'b0000011: begin
        steps.push_back(memadr);
        steps.push_back(st(mk(1,1,0,0,0,0,2'b00,2'b00,2'b00,2'b00), 1, 0, 0));
        steps.push_back(st(mk(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b01), 0, 0, 0));
      end
      7'b0100011: begin
        steps.push_back(memadr);
        steps.push_back(st(mk(1,1,1,0,0,0,2'b00,2'b00,2'b00,2'b00), 1, 0, 0));
      end
      7'b0110011: begin
        steps.push_back(st(mk(0,0,0,0,0,0,2'b10,2'b00,2'b11,2'b00), 0, 0, 0));
        steps.push_back(aluwb);
      end
      7'b0010011: begin
        steps.push_back(st(mk(0,0,0,0,0,0,2'b10,2'b01,2'b10,2'b00), 0, 0, 0));
        steps.push_back(aluwb);
      end
      7'b1100011:
        steps.push_back(st(mk(0,0,0,0,0,0,2'b10,2'b00,2'b01,2'b00), 0, 0, 1));
      7'b1101111: begin
        steps.push_back(st(mk(0,0,0,0,1,0,2'b01,2'b10,2'b00,2'b00), 0, 0, 0));
        steps.push_back(aluwb);
      end
      7'b1100111: begin
        steps.push_back(st(mk(0,0,0,0,1,0,2'b10,2'b01,2'b00,2'b10), 0, 0, 0));
        steps.push_back(st(mk(0,0,0,0,0,1,2'b01,2'b10,2'b00,2'b10), 0, 0, 0));
      end
      7'b0110111:
        steps.push_back(st(mk(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b11), 0, 0, 0));
      7'b0010111:
        steps.push_back(aluwb);
      default: ;
    endcase
  endtask

  // Run one instruction; called just after a rising edge with the DUT in FETCH.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3,
                           input bit rnd, input int memstall,
                           input bit z, input bit n, input bit u);
    logic [13:0] exp;
    int nst;
    Opcode = op;
    funct3 = f3;
    build(op);
    for (int i = 0; i < steps.size(); i++) begin
      nst = 0;
      if (steps[i].req)
        nst = rnd ? (($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0)
                  : (steps[i].fetch ? 0 : memstall);
      for (int k = 0; k <= nst; k++) begin
        if (steps[i].req) mem_ready = (k == nst);
        else              mem_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (rnd) begin
          Zero = 1'($urandom_range(0, 1));
          Negflag = 1'($urandom_range(0, 1));
          Unsigned_less_than = 1'($urandom_range(0, 1));
        end else begin
          Zero = z; Negflag = n; Unsigned_less_than = u;
        end
        @(negedge clk);
        exp = steps[i].vec;
        if (steps[i].fetch) begin
          exp[10] = mem_ready;
          exp[9]  = mem_ready;
        end
        if (steps[i].br) exp[9] = taken(f3, Zero, Negflag, Unsigned_less_than);
        chk($sformatf("ctl op=%b f3=%0d step=%0d", op, f3, i), 32'(ctl_vec), 32'(exp));
        chk("Loadtype", 32'(Loadtype), 32'(lt_of(op, f3)));
        chk("Storetype", 32'(Storetype), 32'(stt_of(op, f3)));
        if (i == 0 && k == 0) chk("retired", retired, 32'(done));
        if (i == 1) begin
          chk("ImmSrc", 32'(ImmSrc), 32'(imm_of(op)));
          chk("illegal", 32'(illegal), 32'd0);
        end
        @(posedge clk);
        #1;
      end
    end
    done++;
  endtask

  initial begin
    // Reset held for three cycles: strobes off, counters clear.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst strobes", 32'({mem_req, MemWrite, IRWrite, PCWrite, RegWrite}), 32'd0);
      chk("rst retired", retired, 32'd0);
      chk("rst illegal", 32'(illegal), 32'd0);
    end
    @(posedge clk);
    #1 reset = 1'b0;

    // Directed instructions from the test plan.
    run_instr(7'b0010011, 3'b000, 0, 0, 0, 0, 0);   // ADDI
    run_instr(7'b0000011, 3'b010, 0, 2, 0, 0, 0);   // LW, 2 stall cycles
    run_instr(7'b0000011, 3'b001, 0, 0, 0, 0, 0);   // LH
    run_instr(7'b0000011, 3'b100, 0, 1, 0, 0, 0);   // LBU
    run_instr(7'b0100011, 3'b000, 0, 1, 0, 0, 0);   // SB
    run_instr(7'b1100011, 3'b000, 0, 0, 1, 0, 0);   // BEQ, Zero=1
    run_instr(7'b1100011, 3'b001, 0, 0, 1, 0, 0);   // BNE, Zero=1
    run_instr(7'b1100011, 3'b110, 0, 0, 0, 0, 1);   // BLTU, ult=1
    run_instr(7'b1100111, 3'b000, 0, 0, 0, 0, 0);   // JALR
    run_instr(7'b1101111, 3'b000, 0, 0, 0, 0, 0);   // JAL
    run_instr(7'b0110111, 3'b000, 0, 0, 0, 0, 0);   // LUI
    run_instr(7'b0010111, 3'b000, 0, 0, 0, 0, 0);   // AUIPC
    run_instr(7'b0110011, 3'b000, 0, 0, 0, 0, 0);   // ADD

    // Randomized instruction stream.
    for (int j = 0; j < 200; j++)
      run_instr(ops[$urandom_range(0, 8)], 3'($urandom_range(0, 7)), 1, 0, 0, 0, 0);

    // Reset in the middle of a stalled store abandons it.
    Opcode = 7'b0100011;
    funct3 = 3'b000;
    mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 mem_ready = 1'b0;
    @(negedge clk);
    chk("store strobe", 32'(MemWrite), 32'd1);
    #1 reset = 1'b1;
    #1 chk("mid-access reset", 32'(ctl_vec), 32'(mk(0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b10)));
    chk("mid-access retired", retired, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    mem_ready = 1'b1;
    done = 0;
    run_instr(7'b0010011, 3'b000, 0, 0, 0, 0, 0);

    // Unsupported opcode traps; illegal is sticky and strobes stay off.
    run_instr(7'b1111111, 3'b000, 0, 0, 0, 0, 0);
    done--;
    for (int c = 0; c < 6; c++) begin
      mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("trap ctl", 32'(ctl_vec), 32'd0);
      chk("trap retired", retired, 32'(done));
      if (c >= 1) chk("trap illegal", 32'(illegal), 32'd1);
      @(posedge clk);
      #1;
    end

    // Reset clears the sticky flag and the counter, then execution resumes.
    reset = 1'b1;
    #1 chk("reset illegal", 32'(illegal), 32'd0);
    chk("reset retired", retired, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    mem_ready = 1'b1;
    done = 0;
    run_instr(7'b0110111, 3'b000, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("final retired", retired, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  // Guard against a stuck simulation.
  initial begin
    #200000;
    $display("FAIL timeout compared=%0d", ncmp);
    $fatal(1, "timeout");
  end

endmodule
